// File: rtl/alu_pipe.sv
// Two-stage pipelined integer ALU with valid/ready on both sides and a pass-through tag.
// Optional macro ALU_SAT_EN enables signed saturating SADD (10) and SSUB (11).
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_z,
  output logic             out_n,
  output logic             out_c,
  output logic             out_v,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);
  localparam int SHW    = $clog2(WIDTH);
  localparam int STAGES = 2;
  localparam int MSB    = WIDTH - 1;

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             z;
    logic             n;
    logic             c;
    logic             v;
    logic             err;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  logic [STAGES:1] vld_pipe_q, vld_pipe_d;
  req_t            req_q, req_d;
  rsp_t            rsp_q, rsp_d, rsp_calc;
  logic            stall;
  logic [WIDTH:0]  r;
  logic [SHW-1:0]  sh;
  logic [WIDTH-1:0] y_c;
  logic            c_c, v_c, err_c;

  // A blocked output freezes every stage; in_ready depends only on flops and out_ready.
  assign stall    = vld_pipe_q[STAGES] && !out_ready;
  assign in_ready = !stall;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    req_d      = req_q;
    rsp_d      = rsp_q;
    if (!stall) begin
      vld_pipe_d = {vld_pipe_q[1], in_valid};
      if (in_valid)      req_d = '{op: in_op, a: in_a, b: in_b, tag: in_tag};
      if (vld_pipe_q[1]) rsp_d = rsp_calc;
    end
  end

  // Execute stage: r is the WIDTH+1-bit intermediate; shifts borrow its extra bit for carry-out.
  always_comb begin
    sh    = req_q.b[SHW-1:0];
    r     = '0;
    y_c   = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    err_c = 1'b0;
    case (req_q.op)
      4'd0: begin
        r   = {1'b0, req_q.a} + {1'b0, req_q.b};
        y_c = r[MSB:0];
        c_c = r[WIDTH];
        v_c = (req_q.a[MSB] == req_q.b[MSB]) && (y_c[MSB] != req_q.a[MSB]);
      end
      4'd1: begin
        r   = {1'b0, req_q.a} - {1'b0, req_q.b};
        y_c = r[MSB:0];
        c_c = r[WIDTH];
        v_c = (req_q.a[MSB] != req_q.b[MSB]) && (y_c[MSB] != req_q.a[MSB]);
      end
      4'd2: y_c = req_q.a & req_q.b;
      4'd3: y_c = req_q.a | req_q.b;
      4'd4: y_c = req_q.a ^ req_q.b;
      4'd5: begin
        r   = {1'b0, req_q.a} << sh;
        y_c = r[MSB:0];
        c_c = r[WIDTH];
      end
      4'd6: begin
        r   = {req_q.a, 1'b0} >> sh;
        y_c = r[WIDTH:1];
        c_c = r[0];
      end
      4'd7: begin
        r   = $signed({req_q.a, 1'b0}) >>> sh;
        y_c = r[WIDTH:1];
        c_c = r[0];
      end
      4'd8: y_c = {{(WIDTH-1){1'b0}}, $signed(req_q.a) < $signed(req_q.b)};
      4'd9: y_c = {{(WIDTH-1){1'b0}}, req_q.a < req_q.b};
`ifdef ALU_SAT_EN
      4'd10: begin
        r   = {1'b0, req_q.a} + {1'b0, req_q.b};
        v_c = (req_q.a[MSB] == req_q.b[MSB]) && (r[MSB] != req_q.a[MSB]);
        y_c = !v_c ? r[MSB:0] :
              req_q.a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
      4'd11: begin
        r   = {1'b0, req_q.a} - {1'b0, req_q.b};
        v_c = (req_q.a[MSB] != req_q.b[MSB]) && (r[MSB] != req_q.a[MSB]);
        y_c = !v_c ? r[MSB:0] :
              req_q.a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
      default: err_c = 1'b1;
    endcase
    rsp_calc = '{y: y_c, z: (y_c == '0), n: y_c[MSB], c: c_c, v: v_c,
                 err: err_c, tag: req_q.tag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      req_q      <= '0;
      rsp_q      <= '0;
      rsp_q.z    <= 1'b1;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      req_q      <= req_d;
      rsp_q      <= rsp_d;
    end
  end

  assign out_valid = vld_pipe_q[STAGES];
  assign out_y     = rsp_q.y;
  assign out_z     = rsp_q.z;
  assign out_n     = rsp_q.n;
  assign out_c     = rsp_q.c;
  assign out_v     = rsp_q.v;
  assign out_err   = rsp_q.err;
  assign out_tag   = rsp_q.tag;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vectors, stalled streams, randomized traffic
// against an integer-arithmetic reference model, and reset with ops in flight.
module tb_alu_pipe;
  localparam int W     = 16;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [3:0]       in_op;
  logic [W-1:0]     in_a, in_b, out_y;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic             out_z, out_n, out_c, out_v, out_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0]     y;
    logic             z, n, c, v, err;
    logic [TAG_W-1:0] tag;
  } exp_t;

  alu_pipe #(.WIDTH(W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_z(out_z), .out_n(out_n), .out_c(out_c), .out_v(out_v), .out_err(out_err),
    .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // Reference: plain signed/unsigned integer arithmetic on 64-bit values.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, b,
                                 input logic [TAG_W-1:0] tag);
    exp_t   e;
    longint m    = longint'(64'd1) << W;
    longint maxs = (m / 2) - 1;
    longint mins = -(m / 2);
    longint ua   = longint'(a);
    longint ub   = longint'(b);
    longint sa   = a[W-1] ? ua - m : ua;
    longint sb   = b[W-1] ? ub - m : ub;
    longint r    = 0;
    longint s;
    int     sh   = int'(ub % W);
    e.c = 0; e.v = 0; e.err = 0;
    case (op)
      4'd0: begin r = ua + ub; e.c = (r >= m); s = sa + sb; e.v = (s > maxs) || (s < mins); end
      4'd1: begin r = ua - ub; e.c = (ua < ub); s = sa - sb; e.v = (s > maxs) || (s < mins); end
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = ua ^ ub;
      4'd5: begin r = ua << sh; e.c = (sh != 0) && (((ua >> (W - sh)) & 1) == 1); end
      4'd6: begin r = ua >> sh; e.c = (sh != 0) && (((ua >> (sh - 1)) & 1) == 1); end
      4'd7: begin r = sa >>> sh; e.c = (sh != 0) && (((ua >> (sh - 1)) & 1) == 1); end
      4'd8: r = (sa < sb) ? 1 : 0;
      4'd9: r = (ua < ub) ? 1 : 0;
`ifdef ALU_SAT_EN
      4'd10, 4'd11: begin
        s = (op == 4'd10) ? sa + sb : sa - sb;
        if (s > maxs)      begin r = maxs; e.v = 1; end
        else if (s < mins) begin r = mins; e.v = 1; end
        else               r = s;
      end
`endif
      default: begin r = 0; e.err = 1; end
    endcase
    e.y   = r[W-1:0];
    e.z   = (e.y == '0);
    e.n   = e.y[W-1];
    e.tag = tag;
    return e;
  endfunction

  function automatic logic [W-1:0] corner(input logic [W-1:0] rnd);
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b0, {(W-1){1'b1}}};
      3: return {1'b1, {(W-1){1'b0}}};
      default: return rnd;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++;
    if ({out_valid, out_y, out_z, out_n, out_c, out_v, out_err, out_tag} !==
        {1'b0, {W{1'b0}}, 1'b1, 4'b0000, {TAG_W{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_state: got vld=%0b y=%h z%0b n%0b c%0b v%0b e%0b tag=%h, want vld=0 y=0 z1 others 0",
               out_valid, out_y, out_z, out_n, out_c, out_v, out_err, out_tag);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    end
  endtask

  typedef struct {
    logic [3:0] op; logic [W-1:0] a, b; logic [TAG_W-1:0] tag;
    logic [W-1:0] y; logic z, n, c, v, err;
  } vec_t;

  task automatic test_directed();
    vec_t v[$];
    v.push_back('{4'd0,  16'hFFFF, 16'h0001, 4'd3, 16'h0000, 1, 0, 1, 0, 0});
    v.push_back('{4'd0,  16'h7FFF, 16'h0001, 4'd5, 16'h8000, 0, 1, 0, 1, 0});
    v.push_back('{4'd1,  16'h0001, 16'h0002, 4'd6, 16'hFFFF, 0, 1, 1, 0, 0});
    v.push_back('{4'd7,  16'h8001, 16'h0001, 4'd7, 16'hC000, 0, 1, 1, 0, 0});
    v.push_back('{4'd5,  16'h1234, 16'h0010, 4'd8, 16'h1234, 0, 0, 0, 0, 0});
    v.push_back('{4'd6,  16'h8001, 16'h0001, 4'd9, 16'h4000, 0, 0, 1, 0, 0});
    v.push_back('{4'd8,  16'hFFFF, 16'h0001, 4'd1, 16'h0001, 0, 0, 0, 0, 0});
    v.push_back('{4'd9,  16'hFFFF, 16'h0001, 4'd2, 16'h0000, 1, 0, 0, 0, 0});
    v.push_back('{4'd12, 16'h1111, 16'h2222, 4'hC, 16'h0000, 1, 0, 0, 0, 1});
`ifdef ALU_SAT_EN
    v.push_back('{4'd10, 16'h7000, 16'h2000, 4'hA, 16'h7FFF, 0, 0, 0, 1, 0});
    v.push_back('{4'd11, 16'h8000, 16'h0001, 4'hB, 16'h8000, 0, 1, 0, 1, 0});
`else
    v.push_back('{4'd10, 16'h7000, 16'h2000, 4'hA, 16'h0000, 1, 0, 0, 0, 1});
`endif
    foreach (v[i]) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = 1'b1; in_op = v[i].op; in_a = v[i].a; in_b = v[i].b; in_tag = v[i].tag;
      @(negedge clk);
      in_valid = 1'b0;
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL latency_early[%0d]: out_valid=%0b want 0", i, out_valid);
      end
      @(negedge clk);
      n_tests++;
      if ({out_valid, out_y, out_z, out_n, out_c, out_v, out_err, out_tag} !==
          {1'b1, v[i].y, v[i].z, v[i].n, v[i].c, v[i].v, v[i].err, v[i].tag}) begin
        n_fail++;
        $display("FAIL directed[%0d] op=%0d: got vld=%0b y=%h z%0b n%0b c%0b v%0b e%0b tag=%h, want y=%h z%0b n%0b c%0b v%0b e%0b tag=%h",
                 i, v[i].op, out_valid, out_y, out_z, out_n, out_c, out_v, out_err, out_tag,
                 v[i].y, v[i].z, v[i].n, v[i].c, v[i].v, v[i].err, v[i].tag);
      end
    end
  endtask

  // Streams n_ops through the pipe; b2b keeps in_valid high and blocks out_ready in cycles 3-5.
  task automatic run_stream(input int n_ops, input bit b2b, input string name);
    exp_t q[$];
    exp_t e;
    int   issued = 0, got = 0, cyc = 0, budget = 40 * n_ops + 50;
    bit   pending = 0, blocked = 0, extra = 0;
    logic [W+TAG_W+4:0] saved, obs;
    in_valid = 1'b0;
    while (got < n_ops && cyc < budget) begin
      @(negedge clk);
      obs = {out_y, out_z, out_n, out_c, out_v, out_err, out_tag};
      if (blocked) begin
        n_tests++;
        if (obs !== saved || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_stall_stable cyc %0d: got %h vld=%0b want %h vld=1", name, cyc, obs, out_valid, saved);
        end
      end
      if (!pending) begin
        if (issued < n_ops && (b2b || $urandom_range(0, 3) != 0)) begin
          in_valid = 1'b1;
          in_op    = 4'($urandom_range(0, 15));
          in_a     = corner(W'($urandom));
          in_b     = corner(W'($urandom));
          in_tag   = b2b ? TAG_W'(issued) : TAG_W'($urandom);
        end else in_valid = 1'b0;
      end
      out_ready = b2b ? !(cyc >= 3 && cyc <= 5) : ($urandom_range(0, 2) != 0);
      #1;
      n_tests++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        n_fail++;
        $display("FAIL %s_in_ready cyc %0d: got %0b want %0b", name, cyc, in_ready, !(out_valid && !out_ready));
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL %s_unexpected cyc %0d: result y=%h tag=%h with none pending", name, cyc, out_y, out_tag);
        end else begin
          e = q.pop_front();
          if ({out_y, out_z, out_n, out_c, out_v, out_err, out_tag} !==
              {e.y, e.z, e.n, e.c, e.v, e.err, e.tag}) begin
            n_fail++;
            $display("FAIL %s_result #%0d: got y=%h z%0b n%0b c%0b v%0b e%0b tag=%h, want y=%h z%0b n%0b c%0b v%0b e%0b tag=%h",
                     name, got, out_y, out_z, out_n, out_c, out_v, out_err, out_tag,
                     e.y, e.z, e.n, e.c, e.v, e.err, e.tag);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in_op, in_a, in_b, in_tag));
        issued++;
        pending = 0;
      end else pending = in_valid;
      blocked = out_valid && !out_ready;
      saved   = obs;
      cyc++;
    end
    n_tests++;
    if (got != n_ops) begin
      n_fail++; $display("FAIL %s_timeout: got %0d results want %0d", name, got, n_ops);
    end
    if (b2b) begin
      n_tests++;
      if (cyc != n_ops + 5) begin
        n_fail++; $display("FAIL %s_throughput: took %0d cycles want %0d", name, cyc, n_ops + 5);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) extra = 1;
    end
    n_tests++;
    if (extra) begin
      n_fail++; $display("FAIL %s_duplicate: out_valid=1 after all results, want 0", name);
    end
  endtask

  task automatic test_back_to_back();
    run_stream(8, 1'b1, "b2b");
  endtask

  task automatic test_random();
    run_stream(300, 1'b0, "rand");
  endtask

  task automatic test_reset_midflight();
    bit seen = 0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 4'd0; in_a = 16'h0001; in_b = 16'h0002; in_tag = 4'h1;
    @(negedge clk);
    in_op = 4'd4; in_a = 16'h00F0; in_b = 16'h0F00; in_tag = 4'h2;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, out_z, out_y} !== {1'b0, 1'b1, {W{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_midflight: got vld=%0b z=%0b y=%h want vld=0 z=1 y=0", out_valid, out_z, out_y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    n_tests++;
    if (seen) begin
      n_fail++; $display("FAIL reset_flush: out_valid=1 after release, want 0");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
